// File: rtl/qlf_fifo_pkg.sv
// rtl/qlf_fifo_pkg.sv - shared constants for the qlf FIFO controllers
package qlf_fifo_pkg;

  // Status flag bit positions, packed as {FULL, FMO, FWM, OVERRUN, EMPTY, EPO, EWM, UNDERRUN}
  localparam int FLAG_UNDERRUN = 0;
  localparam int FLAG_EWM      = 1;
  localparam int FLAG_EPO      = 2;
  localparam int FLAG_EMPTY    = 3;
  localparam int FLAG_OVERRUN  = 4;
  localparam int FLAG_FWM      = 5;
  localparam int FLAG_FMO      = 6;
  localparam int FLAG_FULL     = 7;
  localparam int NUM_FLAGS     = 8;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_flag_gen.sv
// rtl/fifo_flag_gen.sv - registered level-derived FIFO status flags
module fifo_flag_gen
  import qlf_fifo_pkg::*;
#(
  parameter  int ADDR_WIDTH = 10,
  localparam int PW         = ptr_width(ADDR_WIDTH)
)(
  input  logic                  CLK_i,
  input  logic                  RST_i,
  input  logic [PW-1:0]         LEVEL_NXT_i,
  input  logic [ADDR_WIDTH-1:0] UPAF_i,
  input  logic [ADDR_WIDTH-1:0] UPAE_i,
  output logic                  FULL_o,
  output logic                  FMO_o,
  output logic                  FWM_o,
  output logic                  EMPTY_o,
  output logic                  EPO_o,
  output logic                  EWM_o
);

  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PW-1:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [PW-1:0] free_nxt;

  assign free_nxt = DEPTH - LEVEL_NXT_i;

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      FULL_o  <= 1'b0;
      FMO_o   <= 1'b0;
      FWM_o   <= 1'b0;
      EMPTY_o <= 1'b1;
      EPO_o   <= 1'b0;
      EWM_o   <= 1'b1;
    end else begin
      FULL_o  <= (LEVEL_NXT_i == DEPTH);
      FMO_o   <= (LEVEL_NXT_i == DEPTH - ONE);
      FWM_o   <= (free_nxt <= {1'b0, UPAF_i});
      EMPTY_o <= (LEVEL_NXT_i == '0);
      EPO_o   <= (LEVEL_NXT_i == ONE);
      EWM_o   <= (LEVEL_NXT_i <= {1'b0, UPAE_i});
    end
  end

endmodule

// File: rtl/sync_fifo_ctl_fwft.sv
// rtl/sync_fifo_ctl_fwft.sv - single-clock block-RAM FIFO controller with optional FWFT read
module sync_fifo_ctl_fwft
  import qlf_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 36,
  parameter  int ADDR_WIDTH = 10,
  parameter  int FWFT       = FWFT_OFF,
  localparam int PW         = ptr_width(ADDR_WIDTH)
)(
  input  logic                  CLK_i,
  input  logic                  RST_i,
  input  logic                  FLUSH_i,
  input  logic                  WEN_i,
  input  logic [DATA_WIDTH-1:0] WDATA_i,
  input  logic                  REN_i,
  output logic [DATA_WIDTH-1:0] RDATA_o,
  output logic                  RVALID_o,
  input  logic [ADDR_WIDTH-1:0] UPAF_i,
  input  logic [ADDR_WIDTH-1:0] UPAE_i,
  output logic                  RAM_WEN_o,
  output logic [ADDR_WIDTH-1:0] RAM_WADDR_o,
  output logic [DATA_WIDTH-1:0] RAM_WDATA_o,
  output logic                  RAM_REN_o,
  output logic [ADDR_WIDTH-1:0] RAM_RADDR_o,
  input  logic [DATA_WIDTH-1:0] RAM_RDATA_i,
  output logic [PW-1:0]         LEVEL_o,
  output logic                  FULL_o,
  output logic                  FMO_o,
  output logic                  FWM_o,
  output logic                  OVERRUN_o,
  output logic                  EMPTY_o,
  output logic                  EPO_o,
  output logic                  EWM_o,
  output logic                  UNDERRUN_o
);

  localparam bit            IS_FWFT = (FWFT == FWFT_ON);
  localparam logic [PW-1:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [PW-1:0]        wptr_q, rptr_q, level_q, level_nxt;
  logic                 hv_q, rvalid_q, overrun_q, underrun_q;
  logic                 fg_full, fg_fmo, fg_fwm, fg_empty, fg_epo, fg_ewm;
  logic                 empty_now, wr_acc, pop, ram_rd, ovr_set, und_set;
  logic [NUM_FLAGS-1:0] flags;

  assign empty_now = IS_FWFT ? ~hv_q : fg_empty;
  assign wr_acc    = WEN_i & ~fg_full   & ~FLUSH_i;
  assign ovr_set   = WEN_i &  fg_full   & ~FLUSH_i;
  assign pop       = REN_i & ~empty_now & ~FLUSH_i;
  assign und_set   = REN_i &  empty_now & ~FLUSH_i;
  // FWFT refills the head whenever it is missing or being popped this cycle
  assign ram_rd    = IS_FWFT ? ((wptr_q != rptr_q) & (~hv_q | REN_i) & ~FLUSH_i) : pop;

  always_comb begin
    level_nxt = level_q;
    if (FLUSH_i)
      level_nxt = '0;
    else if (wr_acc & ~pop)
      level_nxt = level_q + ONE;
    else if (pop & ~wr_acc)
      level_nxt = level_q - ONE;
  end

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      hv_q       <= 1'b0;
      rvalid_q   <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else if (FLUSH_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      hv_q       <= 1'b0;
      rvalid_q   <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (wr_acc)
        wptr_q <= wptr_q + ONE;
      if (ram_rd)
        rptr_q <= rptr_q + ONE;
      level_q    <= level_nxt;
      hv_q       <= ram_rd | (hv_q & ~REN_i);
      rvalid_q   <= ram_rd;
      overrun_q  <= overrun_q | ovr_set;
      underrun_q <= underrun_q | und_set;
    end
  end

  fifo_flag_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_flag_gen (
    .CLK_i       (CLK_i),
    .RST_i       (RST_i),
    .LEVEL_NXT_i (level_nxt),
    .UPAF_i      (UPAF_i),
    .UPAE_i      (UPAE_i),
    .FULL_o      (fg_full),
    .FMO_o       (fg_fmo),
    .FWM_o       (fg_fwm),
    .EMPTY_o     (fg_empty),
    .EPO_o       (fg_epo),
    .EWM_o       (fg_ewm)
  );

  always_comb begin
    flags                = '0;
    flags[FLAG_FULL]     = fg_full;
    flags[FLAG_FMO]      = fg_fmo;
    flags[FLAG_FWM]      = fg_fwm;
    flags[FLAG_OVERRUN]  = overrun_q;
    flags[FLAG_EMPTY]    = empty_now;
    flags[FLAG_EPO]      = fg_epo;
    flags[FLAG_EWM]      = fg_ewm;
    flags[FLAG_UNDERRUN] = underrun_q;
  end

  assign FULL_o      = flags[FLAG_FULL];
  assign FMO_o       = flags[FLAG_FMO];
  assign FWM_o       = flags[FLAG_FWM];
  assign OVERRUN_o   = flags[FLAG_OVERRUN];
  assign EMPTY_o     = flags[FLAG_EMPTY];
  assign EPO_o       = flags[FLAG_EPO];
  assign EWM_o       = flags[FLAG_EWM];
  assign UNDERRUN_o  = flags[FLAG_UNDERRUN];

  assign LEVEL_o     = level_q;
  assign RDATA_o     = RAM_RDATA_i;
  assign RVALID_o    = IS_FWFT ? hv_q : rvalid_q;

  assign RAM_WEN_o   = wr_acc;
  assign RAM_WADDR_o = wptr_q[ADDR_WIDTH-1:0];
  assign RAM_WDATA_o = WDATA_i;
  assign RAM_REN_o   = ram_rd;
  assign RAM_RADDR_o = rptr_q[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_sync_fifo_ctl_fwft.sv
// tb/tb_sync_fifo_ctl_fwft.sv - directed bench for standard and FWFT FIFO controllers
module tb_sync_fifo_ctl_fwft;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] upaf = 4'd8;
  logic [AW-1:0] upae = 4'd8;

  logic          wen0 = 1'b0, ren0 = 1'b0, flush0 = 1'b0;
  logic [DW-1:0] wdata0 = '0, rdata0, ram_wdata0, ram_rdata0;
  logic          rvalid0, ram_wen0, ram_ren0;
  logic [AW-1:0] ram_waddr0, ram_raddr0;
  logic [AW:0]   level0;
  logic          full0, fmo0, fwm0, ovr_o0, empty0, epo0, ewm0, und_o0;

  logic          wen1 = 1'b0, ren1 = 1'b0, flush1 = 1'b0;
  logic [DW-1:0] wdata1 = '0, rdata1, ram_wdata1, ram_rdata1;
  logic          rvalid1, ram_wen1, ram_ren1;
  logic [AW-1:0] ram_waddr1, ram_raddr1;
  logic [AW:0]   level1;
  logic          full1, fmo1, fwm1, ovr_o1, empty1, epo1, ewm1, und_o1;

  sync_fifo_ctl_fwft #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) dut0 (
    .CLK_i(clk), .RST_i(rst), .FLUSH_i(flush0), .WEN_i(wen0), .WDATA_i(wdata0),
    .REN_i(ren0), .RDATA_o(rdata0), .RVALID_o(rvalid0), .UPAF_i(upaf), .UPAE_i(upae),
    .RAM_WEN_o(ram_wen0), .RAM_WADDR_o(ram_waddr0), .RAM_WDATA_o(ram_wdata0),
    .RAM_REN_o(ram_ren0), .RAM_RADDR_o(ram_raddr0), .RAM_RDATA_i(ram_rdata0),
    .LEVEL_o(level0), .FULL_o(full0), .FMO_o(fmo0), .FWM_o(fwm0), .OVERRUN_o(ovr_o0),
    .EMPTY_o(empty0), .EPO_o(epo0), .EWM_o(ewm0), .UNDERRUN_o(und_o0)
  );

  sync_fifo_ctl_fwft #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) dut1 (
    .CLK_i(clk), .RST_i(rst), .FLUSH_i(flush1), .WEN_i(wen1), .WDATA_i(wdata1),
    .REN_i(ren1), .RDATA_o(rdata1), .RVALID_o(rvalid1), .UPAF_i(upaf), .UPAE_i(upae),
    .RAM_WEN_o(ram_wen1), .RAM_WADDR_o(ram_waddr1), .RAM_WDATA_o(ram_wdata1),
    .RAM_REN_o(ram_ren1), .RAM_RADDR_o(ram_raddr1), .RAM_RDATA_i(ram_rdata1),
    .LEVEL_o(level1), .FULL_o(full1), .FMO_o(fmo1), .FWM_o(fwm1), .OVERRUN_o(ovr_o1),
    .EMPTY_o(empty1), .EPO_o(epo1), .EWM_o(ewm1), .UNDERRUN_o(und_o1)
  );

  // Block RAMs with registered read that hold DO while not read
  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];
  always @(posedge clk) begin
    if (ram_wen0) mem0[ram_waddr0] <= ram_wdata0;
    if (ram_ren0) ram_rdata0 <= mem0[ram_raddr0];
    if (ram_wen1) mem1[ram_waddr1] <= ram_wdata1;
    if (ram_ren1) ram_rdata1 <= mem1[ram_raddr1];
  end

  int n_assert = 0;
  int n_fail = 0;
  int n_pop1 = 0;
  int lvl0 = 0, lvl1 = 0;
  bit ovr0m = 0, und0m = 0, ovr1m = 0, und1m = 0, hv1m = 0;
  logic [DW-1:0] sb0[$];
  logic [DW-1:0] sb1[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_models();
    lvl0 = 0; lvl1 = 0; ovr0m = 0; und0m = 0; ovr1m = 0; und1m = 0; hv1m = 0;
    sb0.delete(); sb1.delete();
  endtask

  // One clock cycle: pre-edge RAM-port and FWFT-data checks, model update, post-edge flag checks
  task automatic tick();
    bit wa0, ra0, wa1, pop1, rr1;
    logic [31:0] exp;
    #1;
    wa0  = wen0 && !flush0 && lvl0 < DEPTH;
    ra0  = ren0 && !flush0 && lvl0 > 0;
    wa1  = wen1 && !flush1 && lvl1 < DEPTH;
    pop1 = ren1 && !flush1 && hv1m;
    rr1  = !flush1 && (lvl1 - (hv1m ? 1 : 0) > 0) && (!hv1m || ren1);
    chk("ram_wen0", ram_wen0, wa0);
    chk("ram_ren0", ram_ren0, ra0);
    chk("ram_ren1", ram_ren1, rr1);
    if (pop1) begin
      exp = (sb1.size() > 0) ? {24'h0, sb1.pop_front()} : 'x;
      chk("fwft_rdata", rdata1, exp);
      n_pop1++;
    end
    @(posedge clk);
    if (flush0) begin
      lvl0 = 0; ovr0m = 0; und0m = 0; sb0.delete();
    end else begin
      if (wen0 && lvl0 == DEPTH) ovr0m = 1;
      if (ren0 && lvl0 == 0) und0m = 1;
      if (wa0) sb0.push_back(wdata0);
      lvl0 = lvl0 + (wa0 ? 1 : 0) - (ra0 ? 1 : 0);
    end
    if (flush1) begin
      lvl1 = 0; ovr1m = 0; und1m = 0; hv1m = 0; sb1.delete();
    end else begin
      if (wen1 && lvl1 == DEPTH) ovr1m = 1;
      if (ren1 && !hv1m) und1m = 1;
      if (wa1) sb1.push_back(wdata1);
      lvl1 = lvl1 + (wa1 ? 1 : 0) - (pop1 ? 1 : 0);
      hv1m = rr1 || (hv1m && !ren1);
    end
    #1;
    chk("level0", level0, lvl0);
    chk("full0", full0, lvl0 == DEPTH);
    chk("fmo0", fmo0, lvl0 == DEPTH - 1);
    chk("fwm0", fwm0, (DEPTH - lvl0) <= int'(upaf));
    chk("empty0", empty0, lvl0 == 0);
    chk("epo0", epo0, lvl0 == 1);
    chk("ewm0", ewm0, lvl0 <= int'(upae));
    chk("overrun0", ovr_o0, ovr0m);
    chk("underrun0", und_o0, und0m);
    chk("rvalid0", rvalid0, ra0);
    if (ra0) begin
      exp = (sb0.size() > 0) ? {24'h0, sb0.pop_front()} : 'x;
      chk("rdata0", rdata0, exp);
    end
    chk("level1", level1, lvl1);
    chk("rvalid1", rvalid1, hv1m);
    chk("empty1", empty1, !hv1m);
    chk("full1", full1, lvl1 == DEPTH);
    chk("fwm1", fwm1, (DEPTH - lvl1) <= int'(upaf));
    chk("ewm1", ewm1, lvl1 <= int'(upae));
    chk("overrun1", ovr_o1, ovr1m);
    chk("underrun1", und_o1, und1m);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level0", level0, 0);
    chk("rst_empty0", empty0, 1);
    chk("rst_ewm0", ewm0, 1);
    chk("rst_full0", full0, 0);
    chk("rst_fwm0", fwm0, 0);
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_empty1", empty1, 1);
    chk("rst_rvalid1", rvalid1, 0);
    rst = 1'b0;

    ren0 = 1; tick(); ren0 = 0;
    chk("underrun_set", und_o0, 1);
    chk("underrun_level", level0, 0);
    flush0 = 1; tick(); flush0 = 0;
    chk("underrun_flush", und_o0, 0);

    for (int i = 0; i < 16; i++) begin
      wen0 = 1; wdata0 = 8'(i * 7 + 3); tick();
      if (i == 14) chk("fmo_at_15", fmo0, 1);
    end
    chk("full_at_16", full0, 1);
    wdata0 = 8'hEE; tick(); wen0 = 0;
    chk("overrun_set", ovr_o0, 1);
    chk("write17_ignored", level0, 16);
    tick();
    chk("overrun_sticky", ovr_o0, 1);

    wen0 = 1; ren0 = 1; wdata0 = 8'h77; tick(); wen0 = 0;
    chk("full_rw_level", level0, 15);
    repeat (7) tick();
    ren0 = 0;
    chk("lvl8_fwm", fwm0, 1);
    chk("lvl8_ewm", ewm0, 1);
    wen0 = 1; wdata0 = 8'h99; tick(); wen0 = 0;
    chk("lvl9_level", level0, 9);
    chk("lvl9_ewm", ewm0, 0);
    upaf = 4'd6; tick();
    chk("upaf_change_fwm", fwm0, 0);
    upaf = 4'd8;
    ren0 = 1; repeat (2) tick(); ren0 = 0;
    chk("lvl7_ewm", ewm0, 1);
    ren0 = 1; repeat (7) tick();
    wen0 = 1; wdata0 = 8'h42; tick(); wen0 = 0; ren0 = 0;
    chk("empty_rw_level", level0, 1);
    chk("empty_rw_underrun", und_o0, 1);
    flush0 = 1; tick(); flush0 = 0;

    wen1 = 1; wdata1 = 8'hA5; tick(); wen1 = 0;
    chk("fwft_edge1_rvalid", rvalid1, 0);
    tick();
    chk("fwft_edge2_rvalid", rvalid1, 1);
    chk("fwft_edge2_rdata", rdata1, 8'hA5);
    n_pop1 = 0;
    for (int i = 0; i < 32; i++) begin
      wen1 = 1; ren1 = 1; wdata1 = 8'(8'h10 + i); tick();
    end
    wen1 = 0;
    for (int i = 0; i < 40 && lvl1 > 0; i++) tick();
    ren1 = 0;
    chk("fwft_drain_level", level1, 0);
    chk("fwft_pop_count", n_pop1, 33);
    flush1 = 1; tick(); flush1 = 0;

    for (int i = 0; i < 5; i++) begin
      wen0 = 1; wen1 = 1; wdata0 = 8'(8'h50 + i); wdata1 = 8'(8'h60 + i); tick();
    end
    wen0 = 0; wen1 = 0;
    ren0 = 1; ren1 = 1;
    #2;
    chk("inflight_ren0", ram_ren0, 1);
    chk("inflight_ren1", ram_ren1, 1);
    rst = 1'b1;
    #1;
    chk("arst_empty0", empty0, 1);
    chk("arst_rvalid0", rvalid0, 0);
    chk("arst_level0", level0, 0);
    chk("arst_empty1", empty1, 1);
    chk("arst_rvalid1", rvalid1, 0);
    chk("arst_level1", level1, 0);
    ren0 = 0; ren1 = 0;
    @(posedge clk); #1;
    chk("arst_rvalid0_edge", rvalid0, 0);
    chk("arst_rvalid1_edge", rvalid1, 0);
    rst = 1'b0;
    reset_models();

    wen0 = 1; wdata0 = 8'hC1; wen1 = 1; wdata1 = 8'hD1; tick();
    wdata0 = 8'hC2; wen1 = 0; tick(); wen0 = 0;
    ren0 = 1; repeat (2) tick(); ren0 = 0;
    tick();
    chk("resume_level0", level0, 0);
    chk("resume_rvalid1", rvalid1, 1);
    chk("resume_rdata1", rdata1, 8'hD1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
